// File: rtl/custom_fifo_pkg.sv
// Shared definitions for the sample/frame packing blocks (gatherer and fifo).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by the gatherer: CUSTOM_GATHER_LAST_EN.
package custom_fifo_pkg;

  // Default sample width and samples per frame, shared with custom_fifo_valid_ready.
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  // Fill counter width for the default frame depth.
  localparam int unsigned cnt_w = $clog2(DEF_DEPTH);

  // One full frame at the default geometry; slot 0 holds the first sample.
  typedef logic [DEF_DEPTH-1:0][DEF_WIDTH-1:0] frame_t;

endpackage

// File: rtl/custom_frame_reg.sv
// DEPTH x WIDTH valid/ready holding register for completed frames.
// Latency: a frame loaded on an edge is visible the following cycle.
// Backpressure: holds data/valid while valid && !down_ready; load may coincide with a drain.
// Ports: clk/arstn (sync active-low), load + load_data from the fill logic,
//        down_ready from downstream, down_valid/data_o to downstream.
module custom_frame_reg
  import custom_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        load,
  input  logic [DEPTH-1:0][WIDTH-1:0] load_data,
  input  logic                        down_ready,
  output logic                        down_valid,
  output logic [DEPTH-1:0][WIDTH-1:0] data_o
);

  // The fill logic only asserts load when the register is empty or draining,
  // so a load always wins and a held frame is never overwritten.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      down_valid <= 1'b0;
      data_o     <= '0;
    end else if (load) begin
      down_valid <= 1'b1;
      data_o     <= load_data;
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/custom_gather_valid_ready.sv
// Serial-to-parallel gatherer: packs DEPTH WIDTH-bit samples into one frame.
// Latency: down_valid rises on the edge accepting the last sample of a frame.
// Backpressure: up_ready drops only when the last slot is pending and the held frame is not draining.
// Ports: clk/arstn (sync active-low); up_valid/up_ready/up_data sample input;
//        down_valid/down_ready/data_o frame output (data_o[0] = first sample).
// Optional: CUSTOM_GATHER_LAST_EN adds up_last to close a short frame (upper slots zero).
module custom_gather_valid_ready
  import custom_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        up_valid,
  output logic                        up_ready,
  input  logic [WIDTH-1:0]            up_data,
`ifdef CUSTOM_GATHER_LAST_EN
  input  logic                        up_last,
`endif
  output logic                        down_valid,
  input  logic                        down_ready,
  output logic [DEPTH-1:0][WIDTH-1:0] data_o
);

  localparam int unsigned CW = $clog2(DEPTH);

  logic [WIDTH-1:0]            col_q [DEPTH];
  logic [CW-1:0]               cnt_q;
  logic                        last_slot;
  logic                        closing;
  logic                        accept;
  logic                        frame_done;
  logic [DEPTH-1:0][WIDTH-1:0] new_frame;

  assign last_slot = (cnt_q == CW'(DEPTH - 1));

  // "closing" means the current handshake, if it happens, completes a frame.
`ifdef CUSTOM_GATHER_LAST_EN
  assign closing = last_slot || (up_valid && up_last);
`else
  assign closing = last_slot;
`endif

  // Combinational from down_ready so a draining frame frees the slot in the same cycle.
  assign up_ready   = !closing || !down_valid || down_ready;
  assign accept     = up_valid && up_ready;
  assign frame_done = accept && closing;

  // Frame built from the collected slots plus the incoming sample; slots above
  // the incoming one are zero (only reachable on an early close).
  always_comb begin
    new_frame = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q) begin
        new_frame[i] = col_q[i];
      end else if (CW'(i) == cnt_q) begin
        new_frame[i] = up_data;
      end
    end
  end

  // Collect storage needs no reset: slots are always written before they are read.
  always_ff @(posedge clk) begin
    if (accept) begin
      col_q[cnt_q] <= up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else if (frame_done) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  custom_frame_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_frame_reg (
    .clk        (clk),
    .arstn      (arstn),
    .load       (frame_done),
    .load_data  (new_frame),
    .down_ready (down_ready),
    .down_valid (down_valid),
    .data_o     (data_o)
  );

endmodule
